// File: rtl/seg_scan_ctrl.sv
// Purpose : 4-digit 7-segment scan controller. Frame-synchronised hex shadow,
//           per-slot blanking gap, optional leading-zero blanking, load/ack handshake.
// Ports   : clk/reset (async, active high); digits_in/dp_in/load capture new data;
//           lz_en enables leading-zero blanking; load_ack/frame_tick are 1-cycle pulses;
//           digit_sel drives the anode decoder; seg_n/dp_n are active-low cathodes.
// Latency : all outputs registered; anode and cathodes change on the same edge.
module seg_scan_ctrl #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] digits_in,
    input  logic [3:0]  dp_in,
    input  logic        lz_en,
    input  logic        load,
    output logic        load_ack,
    output logic        frame_tick,
    output logic [1:0]  digit_sel,
    output logic [6:0]  seg_n,
    output logic        dp_n
);

    localparam int              CW      = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0]   LAST    = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0]   BLANK_C = CW'(BLANK_CYCLES);

    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_SHOW  = 1'b1
    } phase_t;

    logic [CW-1:0] cnt_q,        cnt_d;
    logic [1:0]    sel_q,        sel_d;
    phase_t        phase_q,      phase_d;
    logic [15:0]   stage_dig_q,  stage_dig_d;
    logic [3:0]    stage_dp_q,   stage_dp_d;
    logic [15:0]   shadow_dig_q, shadow_dig_d;
    logic [3:0]    shadow_dp_q,  shadow_dp_d;
    logic          pending_q,    pending_d;
    logic          ack_d, tick_d, dp_d;
    logic [6:0]    seg_d;

    logic          wrap, boundary, commit, lz_blank;
    logic [3:0]    nib, nz_hi;
    logic          dp_bit;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    always_comb begin
        wrap     = (cnt_q == LAST);
        cnt_d    = wrap ? '0 : cnt_q + CW'(1);
        sel_d    = wrap ? sel_q + 2'd1 : sel_q;
        boundary = wrap && (sel_q == 2'd3);
        commit   = boundary && pending_q;

        // A load on the boundary edge still lands in staging; the commit on
        // that edge uses the value staged before it, and pending stays set.
        stage_dig_d  = load ? digits_in : stage_dig_q;
        stage_dp_d   = load ? dp_in     : stage_dp_q;
        pending_d    = load ? 1'b1 : (boundary ? 1'b0 : pending_q);
        shadow_dig_d = commit ? stage_dig_q : shadow_dig_q;
        shadow_dp_d  = commit ? stage_dp_q  : shadow_dp_q;
        ack_d        = commit;
        tick_d       = boundary;

        // Decode from next-state values so cathodes line up with digit_sel.
        nib    = shadow_dig_d[3:0];
        dp_bit = shadow_dp_d[0];
        case (sel_d)
            2'd1: begin nib = shadow_dig_d[7:4];   dp_bit = shadow_dp_d[1]; end
            2'd2: begin nib = shadow_dig_d[11:8];  dp_bit = shadow_dp_d[2]; end
            2'd3: begin nib = shadow_dig_d[15:12]; dp_bit = shadow_dp_d[3]; end
            default: ;
        endcase

        // nz_hi[n]: digit n and everything above it is zero.
        nz_hi[3] = (shadow_dig_d[15:12] == 4'h0);
        nz_hi[2] = nz_hi[3] && (shadow_dig_d[11:8] == 4'h0);
        nz_hi[1] = nz_hi[2] && (shadow_dig_d[7:4]  == 4'h0);
        nz_hi[0] = 1'b0;
        lz_blank = lz_en && nz_hi[sel_d];

        phase_d = (cnt_d < BLANK_C) ? PH_BLANK : PH_SHOW;
        if (phase_d == PH_BLANK) begin
            seg_d = 7'h7F;
            dp_d  = 1'b1;
        end else begin
            seg_d = lz_blank ? 7'h7F : hex7(nib);
            dp_d  = ~dp_bit;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q        <= '0;
            sel_q        <= 2'd0;
            phase_q      <= PH_BLANK;
            stage_dig_q  <= '0;
            stage_dp_q   <= '0;
            shadow_dig_q <= '0;
            shadow_dp_q  <= '0;
            pending_q    <= 1'b0;
            load_ack     <= 1'b0;
            frame_tick   <= 1'b0;
            seg_n        <= 7'h7F;
            dp_n         <= 1'b1;
        end else begin
            cnt_q        <= cnt_d;
            sel_q        <= sel_d;
            phase_q      <= phase_d;
            stage_dig_q  <= stage_dig_d;
            stage_dp_q   <= stage_dp_d;
            shadow_dig_q <= shadow_dig_d;
            shadow_dp_q  <= shadow_dp_d;
            pending_q    <= pending_d;
            load_ack     <= ack_d;
            frame_tick   <= tick_d;
            seg_n        <= seg_d;
            dp_n         <= dp_d;
        end
    end

    assign digit_sel = sel_q;

endmodule
